ha_serial_seq: RTL and testbench

- Bit-serial adder controller that time-shares one half-adder pair (one full-add cell: two half adders plus an OR) across all bit positions of two WIDTH-bit operands.
- Sequences operands LSB-first, one bit per cycle, and holds the carry between cycles.
- Exposes a start/busy/done handshake and registered result outputs.
- Sits behind the tile's ui_in/uio_in pins as the multi-bit arithmetic engine built on the half-adder cell.

---
 rtl/ha_serial_seq_if.sv | 37 +++
 rtl/ha_serial_seq.sv | 161 ++++++++++++++++
 tb/tb_ha_serial_seq.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ha_serial_seq_if.sv
`default_nettype none
//==============================================================================
// Module      : ha_serial_seq_if
// Description : Handshake and operand/result bundle for the bit-serial
//               half-adder sequencer. The requester (master) drives start and
//               the operands; the sequencer (slave) returns busy/done and the
//               registered result.
//               Optional feature macro: HA_SERIAL_SUB_EN (adds the sub input).
// Revision    : 1.0 - initial release
//==============================================================================
interface ha_serial_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef HA_SERIAL_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef HA_SERIAL_SUB_EN
  modport master (output start, output a, output b, output sub,
                  input  busy,  input  done, input sum, input cout);
  modport slave  (input  start, input  a, input  b, input  sub,
                  output busy,  output done, output sum, output cout);
`else
  modport master (output start, output a, output b,
                  input  busy,  input  done, input sum, input cout);
  modport slave  (input  start, input  a, input  b,
                  output busy,  output done, output sum, output cout);
`endif
endinterface
`default_nettype wire

// File: rtl/ha_serial_seq.sv
`default_nettype none
//==============================================================================
// Module      : ha_serial_seq
// Description : Bit-serial adder controller. A single full-add cell (two half
//               adders plus an OR) is time-shared across all WIDTH bit
//               positions, LSB first, one bit per clock, with the carry held
//               in a register between cycles. start/busy/done handshake and
//               registered sum/cout outputs.
//               Optional feature macro: HA_SERIAL_SUB_EN
//                 defined   -> sub input selects (a-b) via ~b and carry-in 1
//                 undefined -> add only, carry-in always 0
// Revision    : 1.0 - initial release
//==============================================================================
module ha_serial_seq #(
  parameter int WIDTH = 8
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  ha_serial_seq_if.slave bus
);

  // Counter just wide enough to index bit WIDTH-1.
  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Reject illegal widths at elaboration rather than building a broken core.
  generate
    if ((WIDTH < 2) || (WIDTH > 32)) begin : g_width_check
      $error("ha_serial_seq: WIDTH must be in 2..32");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_a_sh;     // operand A, shifts right each RUN cycle
  logic [WIDTH-1:0] r_b_sh;     // operand B (or ~B when subtracting)
  logic [WIDTH-1:0] r_res_sh;   // result bits enter at the MSB end
  logic             r_carry;    // carry held between bit positions
  logic [CNT_W-1:0] r_cnt;      // index of the bit processed this cycle
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_b_load;
  logic             w_carry_init;

  // Full-add cell built from two half adders.
  logic             w_s1;
  logic             w_c1;
  logic             w_s;
  logic             w_c2;
  logic             w_carry_nxt;
  logic [WIDTH-1:0] w_res_nxt;

  // A new request is only honoured when no add is in flight.
  assign w_accept = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last   = (r_cnt == CNT_LAST);

`ifdef HA_SERIAL_SUB_EN
  // Subtraction as a + ~b + 1: invert B on load and seed the carry with 1.
  assign w_b_load     = bus.sub ? ~bus.b : bus.b;
  assign w_carry_init = bus.sub;
`else
  assign w_b_load     = bus.b;
  assign w_carry_init = 1'b0;
`endif

  // Half adder 1 combines the operand bits, half adder 2 folds in the carry.
  assign w_s1        = r_a_sh[0] ^ r_b_sh[0];
  assign w_c1        = r_a_sh[0] & r_b_sh[0];
  assign w_s         = w_s1 ^ r_carry;
  assign w_c2        = w_s1 & r_carry;
  assign w_carry_nxt = w_c1 | w_c2;
  assign w_res_nxt   = {w_s, r_res_sh[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; DONE can accept a new request with no dead cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = bus.start ? ST_RUN : ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Serial datapath: load on accept, then one bit per cycle while running.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a_sh   <= bus.a;
      r_b_sh   <= w_b_load;
      r_res_sh <= '0;
      r_carry  <= w_carry_init;
      r_cnt    <= '0;
    end else if (r_state == ST_RUN) begin
      r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_res_sh <= w_res_nxt;
      r_carry  <= w_carry_nxt;
      // Counter parks on the last index instead of wrapping.
      if (!w_last) begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

  // Result registers update only on the edge that finishes the last bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if ((r_state == ST_RUN) && w_last) begin
      r_sum  <= w_res_nxt;
      r_cout <= w_carry_nxt;
    end
  end

  // Status flags come straight from the registered state.
  assign bus.busy = (r_state == ST_RUN);
  assign bus.done = (r_state == ST_DONE);
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_ha_serial_seq.sv
`default_nettype none
//==============================================================================
// Module      : tb_ha_serial_seq
// Description : Self-checking bench for ha_serial_seq (WIDTH=8). Expected
//               results come from plain integer arithmetic on the operands.
//               Optional feature macro: HA_SERIAL_SUB_EN
// Revision    : 1.0 - initial release
//==============================================================================
module tb_ha_serial_seq;

  localparam int W = 8;

  logic clk;
  logic rst_n;

  int checks;
  int failures;

  // Last completed result as the model sees it (held until next completion).
  logic [W-1:0] exp_sum;
  logic         exp_cout;

  ha_serial_seq_if #(.WIDTH(W)) bus ();

  ha_serial_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: {cout,sum} is the (W+1)-bit value of a+b or a+(2^W-1-b)+1.
  function automatic logic [W:0] model(input logic [W-1:0] ma,
                                       input logic [W-1:0] mb,
                                       input logic         msub);
    int unsigned r;
    if (msub) r = int'(ma) + ((1 << W) - 1 - int'(mb)) + 1;
    else      r = int'(ma) + int'(mb);
    return r[W:0];
  endfunction

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_sub(input logic s);
`ifdef HA_SERIAL_SUB_EN
    bus.sub = s;
`else
    if (s) $display("note: sub requested but feature not built");
`endif
  endtask

  // Launch one operation, scramble inputs mid-run, check busy window and result.
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                        input logic os, input string name);
    logic [W:0] r;
    logic       eff_sub;
`ifdef HA_SERIAL_SUB_EN
    eff_sub = os;
`else
    eff_sub = 1'b0;
`endif
    r = model(oa, ob, eff_sub);
    bus.start = 1'b1;
    bus.a     = oa;
    bus.b     = ob;
    drive_sub(eff_sub);
    step();  // E0 accepted
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    for (int i = 0; i < W; i++) begin
      checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.sum !== exp_sum ||
          bus.cout !== exp_cout) begin
        failures++;
        $display("FAIL %s run cycle %0d: busy=%b done=%b sum=%h cout=%b, want busy=1 done=0 sum=%h cout=%b",
                 name, i, bus.busy, bus.done, bus.sum, bus.cout, exp_sum, exp_cout);
      end
      step();
    end
    exp_sum  = r[W-1:0];
    exp_cout = r[W];
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.sum !== exp_sum ||
        bus.cout !== exp_cout) begin
      failures++;
      $display("FAIL %s result: done=%b busy=%b sum=%h cout=%b, want done=1 busy=0 sum=%h cout=%b",
               name, bus.done, bus.busy, bus.sum, bus.cout, exp_sum, exp_cout);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b1;  // reset must win over start
    bus.a     = 8'hA5;
    bus.b     = 8'h5A;
    drive_sub(1'b0);
    repeat (3) step();
    exp_sum  = '0;
    exp_cout = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== 8'h00 || bus.cout !== 1'b0) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b sum=%h cout=%b, want all zero",
               bus.busy, bus.done, bus.sum, bus.cout);
    end
    bus.start = 1'b0;
    rst_n     = 1'b1;
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_directed();
    run_op(8'h5A, 8'h3C, 1'b0, "add_5A_3C");
    run_op(8'hFF, 8'h01, 1'b0, "add_FF_01");
    run_op(8'hFF, 8'hFF, 1'b0, "add_FF_FF");
    run_op(8'h00, 8'h00, 1'b0, "add_00_00");
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      bus.start = 1'b0;
      repeat (gap) step();
      run_op(W'($urandom), W'($urandom), 1'($urandom), "random_op");
    end
  endtask

  // start held high through RUN: second op must launch from the DONE cycle.
  task automatic test_back_to_back();
    logic [W:0] r1;
    logic [W:0] r2;
    int         gap;
    bus.start = 1'b0;
    step();
    step();
    r1 = model(8'h5A, 8'h3C, 1'b0);
    r2 = model(8'h00, 8'h00, 1'b0);
    bus.start = 1'b1;
    bus.a     = 8'h5A;
    bus.b     = 8'h3C;
    drive_sub(1'b0);
    step();
    bus.a = 8'h00;
    bus.b = 8'h00;
    for (int i = 0; i < W; i++) step();
    exp_sum  = r1[W-1:0];
    exp_cout = r1[W];
    checks++;
    if (bus.done !== 1'b1 || bus.sum !== exp_sum || bus.cout !== exp_cout) begin
      failures++;
      $display("FAIL b2b_first: done=%b sum=%h cout=%b, want done=1 sum=%h cout=%b",
               bus.done, bus.sum, bus.cout, exp_sum, exp_cout);
    end
    gap = 0;
    step();  // second accept happens on this edge
    bus.start = 1'b0;
    while (bus.done !== 1'b1 && gap < 20) begin
      checks++;
      if (bus.busy !== 1'b1 || bus.sum !== exp_sum) begin
        failures++;
        $display("FAIL b2b_second_run: busy=%b sum=%h, want busy=1 sum=%h",
                 bus.busy, bus.sum, exp_sum);
      end
      gap++;
      step();
    end
    exp_sum  = r2[W-1:0];
    exp_cout = r2[W];
    checks++;
    if (gap + 1 !== W + 1 || bus.sum !== exp_sum || bus.cout !== exp_cout) begin
      failures++;
      $display("FAIL b2b_second: done spacing=%0d sum=%h cout=%b, want spacing=%0d sum=%h cout=%b",
               gap + 1, bus.sum, bus.cout, W + 1, exp_sum, exp_cout);
    end
  endtask

  task automatic test_reset_midrun();
    run_op(8'h5A, 8'h3C, 1'b0, "pre_abort");
    bus.start = 1'b1;
    bus.a     = 8'h12;
    bus.b     = 8'h34;
    step();  // first RUN cycle follows
    bus.start = 1'b0;
    step();
    step();
    step();  // now in the 4th RUN cycle
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_sum  = '0;
    exp_cout = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== 8'h00 || bus.cout !== 1'b0) begin
      failures++;
      $display("FAIL abort: busy=%b done=%b sum=%h cout=%b, want all zero",
               bus.busy, bus.done, bus.sum, bus.cout);
    end
    for (int i = 0; i < W + 3; i++) begin
      step();
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL abort_no_done: cycle %0d done=%b busy=%b, want 0 0", i, bus.done, bus.busy);
      end
    end
  endtask

  task automatic test_idle_hold();
    run_op(8'hC3, 8'h7E, 1'b0, "pre_idle");
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      step();
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.sum !== exp_sum || bus.cout !== exp_cout) begin
        failures++;
        $display("FAIL idle_hold %0d: done=%b busy=%b sum=%h cout=%b, want 0 0 %h %b",
                 i, bus.done, bus.busy, bus.sum, bus.cout, exp_sum, exp_cout);
      end
    end
  endtask

`ifdef HA_SERIAL_SUB_EN
  task automatic test_sub();
    run_op(8'h10, 8'h01, 1'b1, "sub_10_01");
    run_op(8'h01, 8'h02, 1'b1, "sub_01_02");
    run_op(8'h37, 8'h37, 1'b1, "sub_equal");
  endtask
`endif

  initial begin
    checks    = 0;
    failures  = 0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    drive_sub(1'b0);
    rst_n     = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midrun();
    test_idle_hold();
`ifdef HA_SERIAL_SUB_EN
    test_sub();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, want finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
